// File: rtl/dmem_mmio_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_mmio_responder_if
// Description : Data-memory bus bundle between the processor, the MMIO
//               responder, the dmem syncram and the TX byte consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_mmio_responder_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    // processor side
    logic [ADDR_W-1:0] address_dmem;
    logic [DATA_W-1:0] data;
    logic              wren;
    logic [DATA_W-1:0] q_dmem;
    // syncram side
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;
    // TX drain port
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    // responder view
    modport slave (
        input  address_dmem, data, wren, mem_q, tx_ready,
        output q_dmem, mem_address, mem_data, mem_wren, tx_data, tx_valid
    );

    // surrounding system view (processor + syncram + consumer)
    modport master (
        output address_dmem, data, wren, mem_q, tx_ready,
        input  q_dmem, mem_address, mem_data, mem_wren, tx_data, tx_valid
    );
endinterface
`default_nettype wire

// File: rtl/dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_mmio_responder
// Description : Data-memory port responder. Passes low addresses to the
//               syncram and serves a 4-word MMIO window (cycle counter,
//               TX byte FIFO, status, control) with the same 1-cycle read
//               latency as the syncram.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_mmio_responder #(
    parameter int              ADDR_W     = 12,
    parameter int              DATA_W     = 32,
    parameter int              FIFO_DEPTH = 8,
    parameter logic [ADDR_W-1:0] MMIO_BASE = 12'hF00
) (
    input  wire logic               clock,
    input  wire logic               reset,
    dmem_mmio_responder_if.slave    bus
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [1:0] c_OFF_CYCLE  = 2'd0;
    localparam logic [1:0] c_OFF_TXDATA = 2'd1;
    localparam logic [1:0] c_OFF_STATUS = 2'd2;
    localparam logic [1:0] c_OFF_CTRL   = 2'd3;

    // read-data source selected at the edge the address was sampled
    localparam logic [1:0] c_SEL_NONE = 2'd0;
    localparam logic [1:0] c_SEL_RAM  = 2'd1;
    localparam logic [1:0] c_SEL_REG  = 2'd2;

    // ---------------- state ----------------
    logic [DATA_W-1:0]  r_cycle;
    logic               r_en;
    logic               r_overflow;
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [1:0]         r_sel;
    logic [DATA_W-1:0]  r_rd;

    // ---------------- decode ----------------
    logic [ADDR_W-1:0]  w_offset_full;
    logic [1:0]         w_offset;
    logic               w_is_ram;
    logic               w_is_mmio;
    logic               w_wr_cycle;
    logic               w_wr_txdata;
    logic               w_wr_status;
    logic               w_wr_ctrl;

    assign w_offset_full = bus.address_dmem - MMIO_BASE;
    assign w_offset      = w_offset_full[1:0];
    assign w_is_ram      = (bus.address_dmem < MMIO_BASE);
    assign w_is_mmio     = !w_is_ram && (w_offset_full[ADDR_W-1:2] == '0);

    assign w_wr_cycle  = bus.wren && w_is_mmio && (w_offset == c_OFF_CYCLE);
    assign w_wr_txdata = bus.wren && w_is_mmio && (w_offset == c_OFF_TXDATA);
    assign w_wr_status = bus.wren && w_is_mmio && (w_offset == c_OFF_STATUS);
    assign w_wr_ctrl   = bus.wren && w_is_mmio && (w_offset == c_OFF_CTRL);

    // ---------------- RAM pass-through ----------------
    assign bus.mem_address = bus.address_dmem;
    assign bus.mem_data    = bus.data;
    assign bus.mem_wren    = bus.wren && w_is_ram;

    // ---------------- FIFO control ----------------
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_pop   = !w_empty && bus.tx_ready;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign w_push  = w_wr_txdata && (!w_full || w_pop);
    assign w_drop  = w_wr_txdata && w_full && !w_pop;

    assign bus.tx_valid = !w_empty;
    // storage is not reset, so mask the head byte while empty
    assign bus.tx_data  = w_empty ? 8'h00 : r_mem[r_rptr];

    // ---------------- MMIO read mux (pre-edge values) ----------------
    logic [DATA_W-1:0] w_status;
    logic [DATA_W-1:0] w_rd_val;

    // status word assembly; count field truncates to 8 bits at depth 256
    always_comb begin
        w_status       = '0;
        w_status[0]    = w_empty;
        w_status[1]    = w_full;
        w_status[2]    = r_overflow;
        w_status[15:8] = 8'(r_count);
    end

    // register value selected by the current word offset
    always_comb begin
        w_rd_val = '0;
        case (w_offset)
            c_OFF_CYCLE:  w_rd_val = r_cycle;
            c_OFF_STATUS: w_rd_val = w_status;
            c_OFF_CTRL:   w_rd_val[0] = r_en;
            default:      w_rd_val = '0;
        endcase
    end

    // cycle counter and control enable; a CYCLE write beats the increment
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cycle <= '0;
            r_en    <= 1'b1;
        end else begin
            if (w_wr_cycle)
                r_cycle <= bus.data;
            else if (r_en)
                r_cycle <= r_cycle + 1'b1;
            if (w_wr_ctrl)
                r_en <= bus.data[0];
        end
    end

    // sticky overflow: set by a dropped push, cleared by writing 1 to bit 2
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_overflow <= 1'b0;
        else if (w_drop)
            r_overflow <= 1'b1;
        else if (w_wr_status && bus.data[2])
            r_overflow <= 1'b0;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO byte storage
    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wptr] <= bus.data[7:0];
    end

    // read-side capture: source select and MMIO value, both one cycle late like the syncram
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sel <= c_SEL_NONE;
            r_rd  <= '0;
        end else begin
            r_sel <= w_is_ram ? c_SEL_RAM : c_SEL_REG;
            r_rd  <= (!bus.wren && w_is_mmio) ? w_rd_val : '0;
        end
    end

    assign bus.q_dmem = (r_sel == c_SEL_RAM) ? bus.mem_q : r_rd;

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_mmio_responder
// Description : Self-checking bench for dmem_mmio_responder: vector table
//               plus hand-written reset/latency sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_mmio_responder;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    dmem_mmio_responder_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    dmem_mmio_responder #(
        .ADDR_W     (12),
        .DATA_W     (32),
        .FIFO_DEPTH (8),
        .MMIO_BASE  (12'hF00)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // syncram model: registered address, one-cycle read latency
    logic [31:0] ram [4096];
    always @(posedge clock) begin
        if (bus.mem_wren)
            ram[bus.mem_address] <= bus.mem_data;
        bus.mem_q <= ram[bus.mem_address];
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        rdy;
        logic        chk_q;
        logic [31:0] exp_q;
        logic        exp_valid;
        logic [7:0]  exp_txd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                       input logic rdy, input logic chk_q, input logic [31:0] exp_q,
                       input logic exp_valid, input logic [7:0] exp_txd);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdy = rdy;
        v.chk_q = chk_q; v.exp_q = exp_q; v.exp_valid = exp_valid; v.exp_txd = exp_txd;
        vecs.push_back(v);
    endtask

    initial begin
        // ---- vector table (FIFO starts empty, counter enabled) ----
        // counter wrap: reads return the value before each edge
        add(1, 12'hF00, 32'hFFFF_FFFE, 0, 1, 32'h0,         0, 8'h00);
        add(0, 12'hF00, 32'h0,         0, 1, 32'hFFFF_FFFE, 0, 8'h00);
        add(0, 12'hF00, 32'h0,         0, 1, 32'hFFFF_FFFF, 0, 8'h00);
        add(0, 12'hF00, 32'h0,         0, 1, 32'h0000_0000, 0, 8'h00);
        // disable counter: still increments on the write edge, then holds at 2
        add(1, 12'hF03, 32'h0,         0, 1, 32'h0,         0, 8'h00);
        add(0, 12'hF00, 32'h0,         0, 1, 32'h2,         0, 8'h00);
        add(0, 12'hF00, 32'h0,         0, 1, 32'h2,         0, 8'h00);
        add(0, 12'hF03, 32'h0,         0, 1, 32'h0,         0, 8'h00);
        add(1, 12'hF03, 32'h1,         0, 1, 32'h0,         0, 8'h00);
        add(0, 12'hF03, 32'h0,         0, 1, 32'h1,         0, 8'h00);
        // fill FIFO with 0x41..0x48, consumer stalled
        for (int k = 0; k < 8; k++)
            add(1, 12'hF01, 32'h41 + k, 0, 1, 32'h0, 1, 8'h41);
        add(0, 12'hF02, 32'h0,         0, 1, 32'h0000_0802, 1, 8'h41);
        // ninth byte dropped, overflow sticky, then cleared
        add(1, 12'hF01, 32'h49,        0, 1, 32'h0,         1, 8'h41);
        add(0, 12'hF02, 32'h0,         0, 1, 32'h0000_0806, 1, 8'h41);
        add(1, 12'hF02, 32'h4,         0, 1, 32'h0,         1, 8'h41);
        add(0, 12'hF02, 32'h0,         0, 1, 32'h0000_0802, 1, 8'h41);
        // push while full with a simultaneous pop
        add(1, 12'hF01, 32'h50,        1, 1, 32'h0,         1, 8'h42);
        add(0, 12'hF02, 32'h0,         0, 1, 32'h0000_0802, 1, 8'h42);
        // drain while reading unmapped space (reads as 0)
        add(0, 12'hF10, 32'h0,         1, 1, 32'h0,         1, 8'h43);
        add(0, 12'hF10, 32'h0,         1, 1, 32'h0,         1, 8'h44);
        add(0, 12'hF10, 32'h0,         1, 1, 32'h0,         1, 8'h45);
        add(0, 12'hF10, 32'h0,         1, 1, 32'h0,         1, 8'h46);
        add(0, 12'hF10, 32'h0,         1, 1, 32'h0,         1, 8'h47);
        add(0, 12'hF10, 32'h0,         1, 1, 32'h0,         1, 8'h48);
        add(0, 12'hF10, 32'h0,         1, 1, 32'h0,         1, 8'h50);
        add(0, 12'hF10, 32'h0,         1, 1, 32'h0,         0, 8'h00);
        add(0, 12'hF02, 32'h0,         0, 1, 32'h0000_0001, 0, 8'h00);
        // unmapped write is ignored
        add(1, 12'hF10, 32'h1234,      0, 1, 32'h0,         0, 8'h00);
        add(0, 12'hF02, 32'h0,         0, 1, 32'h0000_0001, 0, 8'h00);
        // RAM write/read interleaved with MMIO reads
        add(1, 12'h010, 32'hDEAD_BEEF, 0, 0, 32'h0,         0, 8'h00);
        add(0, 12'h010, 32'h0,         0, 1, 32'hDEAD_BEEF, 0, 8'h00);
        add(0, 12'hF03, 32'h0,         0, 1, 32'h1,         0, 8'h00);
        add(0, 12'h010, 32'h0,         0, 1, 32'hDEAD_BEEF, 0, 8'h00);
        add(0, 12'hF01, 32'h0,         0, 1, 32'h0,         0, 8'h00);
        add(0, 12'h010, 32'h0,         0, 1, 32'hDEAD_BEEF, 0, 8'h00);

        // ---- reset state ----
        reset = 1'b1;
        bus.address_dmem = '0;
        bus.data         = '0;
        bus.wren         = 1'b0;
        bus.tx_ready     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset q_dmem",   bus.q_dmem,          32'h0);
        check("reset tx_valid", 32'(bus.tx_valid),   32'h0);
        check("reset tx_data",  32'(bus.tx_data),    32'h0);

        // ---- first-cycle counter read, then 10 edges later ----
        reset = 1'b0;
        bus.address_dmem = 12'hF00;
        tick();
        check("cycle first read", bus.q_dmem, 32'd0);
        bus.address_dmem = 12'h000;
        repeat (9) tick();
        bus.address_dmem = 12'hF00;
        tick();
        check("cycle after 10", bus.q_dmem, 32'd10);

        // ---- table ----
        foreach (vecs[i]) begin
            bus.wren         = vecs[i].wr;
            bus.address_dmem = vecs[i].addr;
            bus.data         = vecs[i].wdata;
            bus.tx_ready     = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d mem_wren", i), 32'(bus.mem_wren),
                  32'(vecs[i].wr && (vecs[i].addr < 12'hF00)));
            check($sformatf("vec%0d mem_address", i), 32'(bus.mem_address), 32'(vecs[i].addr));
            @(posedge clock);
            #1;
            if (vecs[i].chk_q)
                check($sformatf("vec%0d q_dmem", i), bus.q_dmem, vecs[i].exp_q);
            check($sformatf("vec%0d tx_valid", i), 32'(bus.tx_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d tx_data", i),  32'(bus.tx_data),  32'(vecs[i].exp_txd));
        end

        // ---- asynchronous reset mid-drain with 3 bytes queued ----
        bus.tx_ready = 1'b0;
        bus.wren     = 1'b1;
        bus.address_dmem = 12'hF01;
        for (int k = 0; k < 3; k++) begin
            bus.data = 32'h61 + k;
            tick();
        end
        bus.wren = 1'b0;
        bus.address_dmem = 12'hF03;
        tick();
        check("pre-reset q_dmem",   bus.q_dmem,        32'h1);
        check("pre-reset tx_valid", 32'(bus.tx_valid), 32'h1);
        check("pre-reset tx_data",  32'(bus.tx_data),  32'h61);
        bus.tx_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("async reset tx_valid", 32'(bus.tx_valid), 32'h0);
        check("async reset tx_data",  32'(bus.tx_data),  32'h0);
        check("async reset q_dmem",   bus.q_dmem,        32'h0);
        bus.address_dmem = 12'hF02;
        tick();
        check("held reset q_dmem", bus.q_dmem, 32'h0);
        reset = 1'b0;
        tick();
        check("post-reset status", bus.q_dmem, 32'h0000_0001);
        bus.address_dmem = 12'hF03;
        tick();
        check("post-reset ctrl",     bus.q_dmem,        32'h1);
        check("post-reset tx_valid", 32'(bus.tx_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
